// File: rtl/ysyx_23060236_axi_sram_slave_pkg.sv
// ysyx_23060236_axi_sram_slave_pkg: shared AXI response codes, FSM states and beat increment
package ysyx_23060236_axi_sram_slave_pkg;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WR, BRESP} state_t;
  function automatic logic [31:0] size_inc(input logic [2:0] size);
    return 32'd1 << size;
  endfunction
endpackage

// File: rtl/ysyx_23060236_sram_1rw.sv
// ysyx_23060236_sram_1rw: single-port word SRAM with registered read and byte write enables
module ysyx_23060236_sram_1rw #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (~|we) rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/ysyx_23060236_axi_sram_slave.sv
// ysyx_23060236_axi_sram_slave: AXI4 responder serving INCR bursts from an on-chip SRAM, one at a time
module ysyx_23060236_axi_sram_slave
  import ysyx_23060236_axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0f00_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clock,
  input  logic        reset,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid
);
  localparam logic [31:0] SPAN = 32'd4 << DEPTH_LOG2;

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  state_t state, state_n;
  logic live, err, rd_ok;
  logic [31:0] addr, addr_nxt, sel, q;
  logic [7:0] len, cnt;
  logic [2:0] size;
  logic ar_hs, aw_hs, r_hs, w_hs, b_hs, sram_en;
  logic [3:0] sram_we;
  logic [DEPTH_LOG2-1:0] sram_idx;

  // live holds the ready outputs low for the cycle after reset releases
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    arready = live && state == IDLE;
    awready = arready && !arvalid;
    wready = state == WR;
    rvalid = state == RD;
    bvalid = state == BRESP;
    rlast = rvalid && cnt == len;
    rresp = (rvalid && !rd_ok) ? SLVERR : OKAY;
    rdata = (rvalid && rd_ok) ? q : '0;
    bresp = (bvalid && err) ? SLVERR : OKAY;
    ar_hs = arvalid && arready;
    aw_hs = awvalid && awready;
    r_hs = rvalid && rready;
    w_hs = wvalid && wready;
    b_hs = bvalid && bready;
    state_n = ar_hs ? RD : aw_hs ? WR : ((r_hs && rlast) || b_hs) ? IDLE : (w_hs && wlast) ? BRESP : state;
    addr_nxt = addr + size_inc(size);
    sel = state == IDLE ? araddr : state == RD ? addr_nxt : addr;
    sram_idx = DEPTH_LOG2'((sel - BASE_ADDR) >> 2);
    sram_en = ar_hs || (r_hs && !rlast) || w_hs;
    sram_we = (w_hs && in_range(addr)) ? wstrb : 4'b0;
  end

  // next read beat is fetched during the current beat's handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      live <= 1'b0;
      err <= 1'b0;
      rd_ok <= 1'b0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      size <= '0;
      rid <= '0;
      bid <= '0;
    end else begin
      live <= 1'b1;
      if (ar_hs) begin
        addr <= araddr;
        len <= arlen;
        size <= arsize;
        rid <= arid;
        cnt <= '0;
        rd_ok <= in_range(araddr);
      end else if (aw_hs) begin
        addr <= awaddr;
        len <= awlen;
        size <= awsize;
        bid <= awid;
        cnt <= '0;
        err <= 1'b0;
      end else if (r_hs && !rlast) begin
        addr <= addr_nxt;
        cnt <= cnt + 8'd1;
        rd_ok <= in_range(addr_nxt);
      end else if (w_hs) begin
        addr <= addr_nxt;
        cnt <= cnt + 8'd1;
        err <= err || !in_range(addr) || (wlast && cnt != len);
      end
    end
  end

  ysyx_23060236_sram_1rw #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clock(clock),
    .en(sram_en),
    .we(sram_we),
    .addr(sram_idx),
    .wdata(wdata),
    .rdata(q)
  );
endmodule

// File: tb/tb_ysyx_23060236_axi_sram_slave.sv
// tb_ysyx_23060236_axi_sram_slave: directed and random AXI bursts checked against a word-array memory model
module tb_ysyx_23060236_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h0f00_0000;
  localparam int DL = 10;
  localparam logic [31:0] SPAN = 32'd4 << DL;

  logic clock, reset;
  logic awready, awvalid, wready, wvalid, wlast, bready, bvalid, arready, arvalid, rready, rvalid, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] awid, wstrb, bid, arid, rid;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] bresp, rresp;

  int checks = 0, errors = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] wd [256];
  logic [3:0] ws [256];

  ysyx_23060236_axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL)) dut (
    .clock(clock), .reset(reset),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a >= BASE && a < BASE + SPAN;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (in_rng(a)) return ref_mem[widx(a)];
    return 32'h0;
  endfunction

  task automatic do_write(input logic [31:0] a, input int len, input int beats, input logic [2:0] sz,
                          input logic [3:0] id, input bit gaps);
    logic [31:0] p;
    bit err;
    int t;
    p = a;
    err = 0;
    awaddr = a; awlen = 8'(len); awsize = sz; awid = id; awvalid = 1;
    #1;
    chk("wready_before_aw", wready, 0);
    t = 0;
    while (awready !== 1 && t < 200) begin step(); t++; end
    chk("aw_wait", t < 200, 1);
    step();
    awvalid = 0;
    for (int i = 0; i < beats; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin wvalid = 0; step(); end
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == beats - 1); wvalid = 1;
      #1;
      t = 0;
      while (wready !== 1 && t < 50) begin step(); t++; end
      chk("w_wait", t < 50, 1);
      step();
      if (in_rng(p)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[widx(p)][8*b +: 8] = wd[i][8*b +: 8];
      end else err = 1;
      p += 32'd1 << sz;
    end
    wvalid = 0; wlast = 0;
    if (beats != len + 1) err = 1;
    chk("bvalid_rise", bvalid, 1);
    chk("bresp", bresp, err ? 2 : 0);
    chk("bid", bid, id);
    repeat ($urandom_range(0, 2)) begin step(); chk("bvalid_hold", bvalid, 1); end
    bready = 1;
    step();
    bready = 0;
    #1;
    chk("bvalid_fall", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [3:0] id,
                         input int mode, input int abort);
    logic [31:0] p;
    int t;
    bit rr;
    p = a;
    chk("rvalid_before_ar", rvalid, 0);
    araddr = a; arlen = 8'(len); arsize = sz; arid = id; arvalid = 1;
    #1;
    t = 0;
    while (arready !== 1 && t < 200) begin step(); t++; end
    chk("ar_wait", t < 200, 1);
    step();
    arvalid = 0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort) begin
        reset = 1; rready = 0;
        step();
        chk("rst_rvalid", rvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rdata", rdata, 0);
        reset = 0;
        step();
        chk("rst_arready_back", arready, 1);
        return;
      end
      t = 0;
      do begin
        rr = mode == 0 ? 1'b1 : mode == 1 ? (t % 2 == 1) : 1'($urandom_range(0, 1));
        rready = rr;
        #1;
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, exp_rd(p));
        chk("rresp", rresp, in_rng(p) ? 0 : 2);
        chk("rlast", rlast, i == len);
        chk("rid", rid, id);
        step();
        t++;
      end while (!rr && t < 50);
      p += 32'd1 << sz;
    end
    rready = 0;
    #1;
    chk("rvalid_after_last", rvalid, 0);
    chk("arready_after_last", arready, 1);
  endtask

  initial begin
    logic [31:0] a;
    int r, len;
    reset = 1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; rready = 0;
    step(); step();
    chk("reset_arready", arready, 0);
    chk("reset_awready", awready, 0);
    chk("reset_wready", wready, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_bvalid", bvalid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rlast", rlast, 0);
    chk("reset_rid", rid, 0);
    chk("reset_bid", bid, 0);
    chk("reset_resp", {bresp, rresp}, 0);
    reset = 0;
    step();
    chk("post_reset_arready", arready, 1);
    chk("post_reset_awready", awready, 1);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
      do_write(BASE + 32'(k * 1024), 255, 256, 2, 4'(k), k[0]);
    end

    wd[0] = 32'hdeadbeef; ws[0] = 4'hf;
    do_write(BASE + 32'h10, 0, 1, 2, 1, 0);
    do_read(BASE + 32'h10, 0, 2, 3, 0, -1);

    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
    ws[2] = 4'b0101;
    do_write(BASE + 32'h100, 3, 4, 2, 9, 1);
    do_read(BASE + 32'h100, 3, 2, 4, 2, -1);

    do_read(BASE + 32'h200, 3, 2, 6, 1, -1);

    do_read(BASE + SPAN - 4, 1, 2, 2, 0, -1);
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
    do_write(BASE + SPAN - 4, 1, 2, 2, 4'ha, 0);
    do_read(BASE + SPAN - 4, 1, 2, 2, 0, -1);
    do_read(BASE, 0, 2, 1, 0, -1);

    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
    do_write(BASE + 32'h300, 3, 2, 2, 4'hc, 0);
    do_read(BASE + 32'h300, 3, 2, 5, 0, -1);

    awaddr = BASE + 32'h400; awlen = 0; awsize = 2; awid = 5; awvalid = 1;
    araddr = BASE + 32'h400; arlen = 2; arsize = 2; arid = 7; arvalid = 1;
    #1;
    chk("both_awready", awready, 0);
    chk("both_arready", arready, 1);
    do_read(BASE + 32'h400, 2, 2, 7, 0, -1);
    wd[0] = $urandom; ws[0] = 4'hf;
    do_write(BASE + 32'h400, 0, 1, 2, 5, 0);
    do_read(BASE + 32'h400, 0, 2, 7, 0, -1);

    do_read(BASE + 32'h40, 7, 2, 1, 0, 2);
    do_read(BASE + 32'h40, 7, 2, 1, 2, -1);

    repeat (40) begin
      r = $urandom_range(0, 9);
      a = r == 0 ? BASE + SPAN - 8 : r == 1 ? BASE - 8 : BASE + 32'($urandom_range(0, 1023) * 4);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(a, len, len + 1, 3'($urandom_range(0, 2)), 4'($urandom), 1);
      end else
        do_read(a, len, 3'($urandom_range(0, 2)), 4'($urandom), $urandom_range(0, 2), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
